// File: rtl/video_rd_scheduler.sv
// Frame-buffer read scheduler: flushes the pixel FIFO at frame start, then issues
// fixed-length burst reads throttled by FIFO fill level until the frame is fetched.
module video_rd_scheduler #(
    parameter int                ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_WORDS = 921600,
    parameter int                BURST_LEN   = 64,
    parameter int                FIFO_DEPTH  = 512,
    parameter int                LVL_W       = 10
) (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic              fifo_empty,
    input  logic              data_req,
    output logic              fifo_flush,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_valid,
    output logic              busy,
    output logic              frame_done,
    input  logic              err_clr,
    output logic              err_underrun
);

    localparam int             LW1     = LVL_W + 1;
    localparam logic [20:0]    FRAME_W = 21'(FRAME_WORDS);
    localparam logic [20:0]    BURST_W = 21'(BURST_LEN);
    localparam logic [7:0]     BURST_B = 8'(BURST_LEN);
    localparam logic [LVL_W:0] DEPTH_L = LW1'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_CHECK, S_REQ, S_DATA, S_DONE
    } state_t;

    state_t      state, next_state;
    logic [20:0] words_left;
    logic [7:0]  beat_cnt;
    logic        restart_pend;

    logic [7:0]  len_c;
    logic [LVL_W:0] need_c;
    logic        last_beat;

    always_comb begin
        len_c      = (words_left < BURST_W) ? words_left[7:0] : BURST_B;
        // widened by one bit so level + burst cannot wrap before the compare
        need_c     = {1'b0, fifo_level} + LW1'(len_c);
        last_beat  = rd_valid && (beat_cnt == rd_len - 8'd1);
        next_state = state;
        case (state)
            S_IDLE:  if (frame_start && enable) next_state = S_FLUSH;
            S_FLUSH: next_state = S_CHECK;
            S_CHECK: begin
                if (restart_pend || frame_start)      next_state = S_FLUSH;
                else if (!enable || words_left == '0) next_state = S_DONE;
                else if (need_c <= DEPTH_L)           next_state = S_REQ;
            end
            S_REQ:   if (rd_ack) next_state = S_DATA;
            S_DATA:  if (last_beat) next_state = S_CHECK;
            S_DONE:  next_state = frame_start ? S_FLUSH : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= next_state;
    end

    // Outputs are registered from next_state so they line up with the state they describe
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_flush   <= 1'b0;
            rd_req       <= 1'b0;
            rd_addr      <= BASE_ADDR;
            rd_len       <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            words_left   <= '0;
            beat_cnt     <= '0;
            restart_pend <= 1'b0;
        end else begin
            fifo_flush <= (next_state == S_FLUSH);
            rd_req     <= (next_state == S_REQ);
            busy       <= (next_state != S_IDLE);
            frame_done <= (state == S_CHECK) && (next_state == S_DONE) && (words_left == '0);
            case (state)
                S_FLUSH: begin
                    rd_addr      <= BASE_ADDR;
                    words_left   <= FRAME_W;
                    restart_pend <= 1'b0;
                end
                S_CHECK: if (next_state == S_REQ) rd_len <= len_c;
                S_REQ: begin
                    if (rd_ack)      beat_cnt     <= '0;
                    if (frame_start) restart_pend <= 1'b1;
                end
                S_DATA: begin
                    if (frame_start) restart_pend <= 1'b1;
                    if (last_beat) begin
                        rd_addr    <= rd_addr + ADDR_W'(rd_len);
                        words_left <= words_left - 21'(rd_len);
                    end else if (rd_valid) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                  err_underrun <= 1'b0;
        else if (err_clr)                err_underrun <= 1'b0;
        else if (data_req && fifo_empty) err_underrun <= 1'b1;
    end

endmodule

// File: tb/tb_video_rd_scheduler.sv
// Directed bench for video_rd_scheduler with a 200-word frame and 64-word bursts.
module tb_video_rd_scheduler;

    logic        pixel_clk, sys_rst_n;
    logic        enable, frame_start, fifo_empty, data_req;
    logic [9:0]  fifo_level;
    logic        fifo_flush, rd_req, rd_ack, rd_valid, busy, frame_done;
    logic [27:0] rd_addr;
    logic [7:0]  rd_len;
    logic        err_clr, err_underrun;

    int total = 0;
    int bad   = 0;
    int n_done = 0, n_flush = 0, n_req = 0;
    logic req_q = 1'b0;

    int exp_addr[4] = '{0, 64, 128, 192};
    int exp_len[4]  = '{64, 64, 64, 8};

    video_rd_scheduler #(
        .ADDR_W(28), .BASE_ADDR(28'h0), .FRAME_WORDS(200),
        .BURST_LEN(64), .FIFO_DEPTH(512), .LVL_W(10)
    ) dut (
        .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .enable(enable),
        .frame_start(frame_start), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
        .data_req(data_req), .fifo_flush(fifo_flush), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .busy(busy), .frame_done(frame_done), .err_clr(err_clr),
        .err_underrun(err_underrun)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    always @(negedge pixel_clk) begin
        if (frame_done) n_done++;
        if (fifo_flush) n_flush++;
        if (rd_req && !req_q) n_req++;
        req_q <= rd_req;
    end

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok && busy; i++) begin
            if (rd_req) ok = 1'b1;
            else        tick();
        end
        if (rd_req) ok = 1'b1;
    endtask

    // Accept the pending request after ack_delay cycles, then stream rd_len beats.
    task automatic serve(input int ack_delay, input int abort_at, input int dis_at,
                         output int unstable);
        logic [27:0] a0;
        logic [7:0]  l0;
        a0 = rd_addr;
        l0 = rd_len;
        unstable = 0;
        repeat (ack_delay) begin
            tick();
            if (!rd_req || rd_addr !== a0 || rd_len !== l0) unstable++;
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        if (rd_req) unstable++;
        for (int b = 0; b < int'(l0); b++) begin
            rd_valid = 1'b1;
            if (b == abort_at) frame_start = 1'b1;
            if (b == dis_at)   enable = 1'b0;
            tick();
            frame_start = 1'b0;
        end
        rd_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        int u;
        fifo_level = '0;
        for (int k = 0; k < 20 && busy; k++) begin
            wait_req(ok);
            if (ok) serve(0, -1, -1, u);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        enable = 1'b0; frame_start = 1'b0; fifo_level = '0; fifo_empty = 1'b0;
        data_req = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req got=%b want=0", rd_req); end
        total++; if (fifo_flush !== 1'b0 || frame_done !== 1'b0) begin bad++;
            $display("FAIL reset_pulses flush=%b done=%b want=0", fifo_flush, frame_done); end
        total++; if (rd_addr !== 28'h0 || rd_len !== 8'h0) begin bad++;
            $display("FAIL reset_addr_len addr=%h len=%0d want=0/0", rd_addr, rd_len); end
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_underrun); end
    endtask

    task automatic test_frame();
        bit ok;
        int u, d0;
        enable = 1'b1;
        d0 = n_done;
        start_frame();
        for (int i = 0; i < 4; i++) begin
            wait_req(ok);
            total++; if (!ok) begin bad++; $display("FAIL frame_req%0d timeout got=no_req want=req", i); end
            total++; if (int'(rd_addr) != exp_addr[i] || int'(rd_len) != exp_len[i]) begin bad++;
                $display("FAIL frame_burst%0d got=(%0d,%0d) want=(%0d,%0d)", i, rd_addr, rd_len, exp_addr[i], exp_len[i]); end
            serve(0, -1, -1, u);
            total++; if (u != 0) begin bad++; $display("FAIL frame_handshake%0d glitches=%0d want=0", i, u); end
        end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_early got=%b want=0", frame_done); end
        tick();
        total++; if (frame_done !== 1'b1 || busy !== 1'b1) begin bad++;
            $display("FAIL frame_done_pulse done=%b busy=%b want=1/1", frame_done, busy); end
        tick();
        total++; if (frame_done !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL frame_idle done=%b busy=%b want=0/0", frame_done, busy); end
        repeat (3) tick();
        total++; if (n_done - d0 != 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", n_done - d0); end
    endtask

    task automatic test_latency();
        int u;
        enable = 1'b1;
        total++; if (fifo_flush !== 1'b0) begin bad++; $display("FAIL lat_flush_before got=%b want=0", fifo_flush); end
        start_frame();
        total++; if (fifo_flush !== 1'b1 || rd_req !== 1'b0) begin bad++;
            $display("FAIL lat_n1 flush=%b req=%b want=1/0", fifo_flush, rd_req); end
        tick();
        total++; if (fifo_flush !== 1'b0 || rd_req !== 1'b0) begin bad++;
            $display("FAIL lat_n2 flush=%b req=%b want=0/0", fifo_flush, rd_req); end
        tick();
        total++; if (rd_req !== 1'b1 || rd_addr !== 28'h0 || rd_len !== 8'd64) begin bad++;
            $display("FAIL lat_n3 req=%b addr=%0d len=%0d want=1/0/64", rd_req, rd_addr, rd_len); end
        serve(5, -1, -1, u);
        total++; if (u != 0) begin bad++; $display("FAIL lat_hold glitches=%0d want=0", u); end
        drain();
    endtask

    task automatic test_throttle();
        int hi = 0;
        int u;
        enable = 1'b1;
        fifo_level = 10'd460;
        start_frame();
        repeat (8) begin tick(); if (rd_req) hi++; end
        total++; if (hi != 0 || busy !== 1'b1) begin bad++;
            $display("FAIL thr_460 req_cycles=%0d busy=%b want=0/1", hi, busy); end
        fifo_level = 10'd449;
        repeat (3) begin tick(); if (rd_req) hi++; end
        total++; if (hi != 0) begin bad++; $display("FAIL thr_449 req_cycles=%0d want=0", hi); end
        fifo_level = 10'd448;
        tick();
        total++; if (rd_req !== 1'b1 || rd_len !== 8'd64 || rd_addr !== 28'h0) begin bad++;
            $display("FAIL thr_448 req=%b len=%0d addr=%0d want=1/64/0", rd_req, rd_len, rd_addr); end
        fifo_level = '0;
        serve(0, -1, -1, u);
        drain();
    endtask

    task automatic test_restart();
        bit ok;
        int u, d0;
        enable = 1'b1;
        d0 = n_done;
        start_frame();
        wait_req(ok);
        serve(0, 30, -1, u);
        total++; if (u != 0 || fifo_flush !== 1'b0) begin bad++;
            $display("FAIL rst_burst glitches=%0d flush=%b want=0/0", u, fifo_flush); end
        tick();
        total++; if (fifo_flush !== 1'b1) begin bad++; $display("FAIL rst_flush got=%b want=1", fifo_flush); end
        wait_req(ok);
        total++; if (!ok || rd_addr !== 28'h0 || rd_len !== 8'd64) begin bad++;
            $display("FAIL rst_readdr ok=%b addr=%0d len=%0d want=1/0/64", ok, rd_addr, rd_len); end
        total++; if (n_done != d0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", n_done - d0); end
        drain();
        total++; if (n_done - d0 != 1) begin bad++; $display("FAIL rst_done_after got=%0d want=1", n_done - d0); end
    endtask

    task automatic test_enable();
        bit ok;
        int u, d0, r0, f0;
        enable = 1'b1;
        d0 = n_done;
        start_frame();
        wait_req(ok);
        serve(0, -1, -1, u);
        wait_req(ok);
        total++; if (!ok || rd_addr !== 28'd64) begin bad++;
            $display("FAIL en_second ok=%b addr=%0d want=1/64", ok, rd_addr); end
        serve(0, -1, 10, u);
        r0 = n_req;
        repeat (5) tick();
        total++; if (busy !== 1'b0 || n_req != r0) begin bad++;
            $display("FAIL en_stop busy=%b new_reqs=%0d want=0/0", busy, n_req - r0); end
        total++; if (n_done != d0) begin bad++; $display("FAIL en_no_done got=%0d want=0", n_done - d0); end
        f0 = n_flush;
        start_frame();
        repeat (4) tick();
        total++; if (busy !== 1'b0 || n_flush != f0) begin bad++;
            $display("FAIL en_ignore busy=%b flushes=%0d want=0/0", busy, n_flush - f0); end
        enable = 1'b1;
    endtask

    task automatic test_underrun();
        data_req = 1'b1; fifo_empty = 1'b0;
        tick();
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL urun_nonempty got=%b want=0", err_underrun); end
        fifo_empty = 1'b1;
        tick();
        data_req = 1'b0;
        total++; if (err_underrun !== 1'b1) begin bad++; $display("FAIL urun_set got=%b want=1", err_underrun); end
        repeat (3) tick();
        total++; if (err_underrun !== 1'b1) begin bad++; $display("FAIL urun_sticky got=%b want=1", err_underrun); end
        err_clr = 1'b1; data_req = 1'b1;
        tick();
        err_clr = 1'b0; data_req = 1'b0;
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL urun_clr_prio got=%b want=0", err_underrun); end
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; fifo_empty = 1'b0;
        total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL urun_clr got=%b want=0", err_underrun); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_latency();
        test_throttle();
        test_restart();
        test_enable();
        test_underrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
